// File: rtl/noc_pkg.sv
// Shared NoC types and default sizing for the wormhole output-port arbiter.
package noc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_AGENTS = 4;
  localparam int DEF_CREDITS    = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr, wrapping upward.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_onehot,
  output logic [IW-1:0] win_idx,
  output logic          win_any
);

  logic [IW-1:0] pos;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    pos        = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!win_any && cand[pos]) begin
        win_any         = 1'b1;
        win_onehot[pos] = 1'b1;
        win_idx         = pos;
      end
    end
  end

endmodule

// File: rtl/wormhole_out_arb.sv
// Wormhole output-port arbiter: round-robin packet lock on head flits, released by tail, gated by downstream credits.
module wormhole_out_arb
  import noc_pkg::*;
#(
  parameter int NUM_AGENTS = DEF_NUM_AGENTS,
  parameter int CREDITS    = DEF_CREDITS,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int IW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_AGENTS-1:0] req_valid,
  input  logic [NUM_AGENTS-1:0] req_head,
  input  logic [NUM_AGENTS-1:0] req_tail,
  output logic [NUM_AGENTS-1:0] req_ready,
  output logic [NUM_AGENTS-1:0] grant,
  output logic                  out_valid,
  output logic [IW-1:0]         out_sel,
  input  logic                  credit_return,
  output logic [CW-1:0]         credits,
  output logic                  credit_err
);

  arb_state_e            state;
  logic [NUM_AGENTS-1:0] cand;
  logic [NUM_AGENTS-1:0] win_onehot;
  logic [IW-1:0]         win_idx;
  logic                  win_any;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         owner;
  logic                  credit_ok;
  logic                  xfer_tail;

  // Only fresh packet heads compete, and only while the port is unowned.
  assign cand = (state == IDLE) ? (req_valid & req_head) : '0;

  rr_pick #(
    .N  (NUM_AGENTS),
    .IW (IW)
  ) u_pick (
    .cand       (cand),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign credit_ok = (credits != '0);
  assign req_ready = (state == LOCKED && credit_ok) ? (grant & req_valid) : '0;
  assign out_valid = |req_ready;
  assign xfer_tail = |(req_ready & req_tail);
  assign out_sel   = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state <= LOCKED;
            grant <= win_onehot;
            owner <= win_idx;
          end
        end
        LOCKED: begin
          // Head bits mid-packet are ignored; only a transferred tail releases the port.
          if (xfer_tail) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= (owner == IW'(NUM_AGENTS - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          owner <= '0;
        end
      endcase
    end
  end

  // A transfer and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits    <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      credit_err <= credit_return && !out_valid && (credits == CW'(CREDITS));
      if (out_valid && !credit_return) begin
        credits <= credits - 1'b1;
      end else if (credit_return && !out_valid && (credits != CW'(CREDITS))) begin
        credits <= credits + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wormhole_out_arb.sv
// Self-checking bench for wormhole_out_arb: queue-free behavioural model compared every cycle plus directed literal checks.
module tb_wormhole_out_arb;

  localparam int NA  = 4;
  localparam int CR  = 4;
  localparam int CW  = $clog2(CR + 1);
  localparam int IW  = $clog2(NA);

  logic          clk;
  logic          rst;
  logic [NA-1:0] reqValid;
  logic [NA-1:0] reqHead;
  logic [NA-1:0] reqTail;
  logic [NA-1:0] reqReady;
  logic [NA-1:0] grant;
  logic          outValid;
  logic [IW-1:0] outSel;
  logic          creditReturn;
  logic [CW-1:0] credits;
  logic          creditErr;

  int errors = 0;
  int checks = 0;

  wormhole_out_arb #(
    .NUM_AGENTS (NA),
    .CREDITS    (CR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (reqValid),
    .req_head      (reqHead),
    .req_tail      (reqTail),
    .req_ready     (reqReady),
    .grant         (grant),
    .out_valid     (outValid),
    .out_sel       (outSel),
    .credit_return (creditReturn),
    .credits       (credits),
    .credit_err    (creditErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait to mid-cycle.
  task automatic applyStimulus(input logic [NA-1:0] v, input logic [NA-1:0] h,
                               input logic [NA-1:0] t, input logic cr);
    @(posedge clk);
    #1;
    reqValid     = v;
    reqHead      = h;
    reqTail      = t;
    creditReturn = cr;
    @(negedge clk);
  endtask

  // Behavioural model: owner index (-1 when free), round-robin start, credit count.
  int mOwner = -1;
  int mPtr   = 0;
  int mCred  = CR;
  bit mErr   = 1'b0;

  always @(negedge clk) begin : modelBlk
    logic [NA-1:0] eGrant;
    logic [NA-1:0] eReady;
    int            eSel;
    bit            xfer;
    bit            isTail;
    bit            nErr;
    if (rst) begin
      mOwner = -1;
      mPtr   = 0;
      mCred  = CR;
      mErr   = 1'b0;
    end
    eGrant = '0;
    eReady = '0;
    eSel   = 0;
    if (mOwner >= 0) begin
      eGrant = NA'(1 << mOwner);
      eSel   = mOwner;
      if (mCred > 0 && reqValid[mOwner]) eReady = eGrant;
    end
    checkOutput("model.grant", 32'(grant), 32'(eGrant));
    checkOutput("model.req_ready", 32'(reqReady), 32'(eReady));
    checkOutput("model.out_valid", 32'(outValid), 32'(eReady != '0));
    checkOutput("model.out_sel", 32'(outSel), 32'(eSel));
    checkOutput("model.credits", 32'(credits), 32'(mCred));
    checkOutput("model.credit_err", 32'(creditErr), 32'(mErr));
    if (!rst) begin
      xfer   = (eReady != '0);
      isTail = xfer && reqTail[eSel];
      nErr   = creditReturn && !xfer && (mCred == CR);
      if (xfer && !creditReturn) mCred = mCred - 1;
      else if (creditReturn && !xfer && mCred < CR) mCred = mCred + 1;
      mErr = nErr;
      if (mOwner < 0) begin
        for (int k = 0; k < NA; k++) begin
          if (mOwner < 0 && reqValid[(mPtr + k) % NA] && reqHead[(mPtr + k) % NA])
            mOwner = (mPtr + k) % NA;
        end
      end else if (isTail) begin
        mPtr   = (mOwner + 1) % NA;
        mOwner = -1;
      end
    end
  end

  initial begin
    rst          = 1'b1;
    reqValid     = '0;
    reqHead      = '0;
    reqTail      = '0;
    creditReturn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.grant", 32'(grant), 32'h0);
    checkOutput("reset.credits", 32'(credits), 32'd4);
    checkOutput("reset.credit_err", 32'(creditErr), 32'h0);
    checkOutput("reset.out_sel", 32'(outSel), 32'h0);

    // Single-flit packet from agent 0.
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0);
    checkOutput("single.idle_ready", 32'(reqReady), 32'h0);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0);
    checkOutput("single.grant", 32'(grant), 32'b0001);
    checkOutput("single.ready", 32'(reqReady), 32'b0001);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("single.release", 32'(grant), 32'h0);
    checkOutput("single.credits", 32'(credits), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);

    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Fairness: everyone streams single-flit heads; credits returned on every transfer.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1111, 4'b1111, 4'b1111, (k % 2) == 1);
      if ((k % 2) == 1) checkOutput("fair.grant", 32'(grant), 32'(1 << (((k - 1) / 2) % 4)));
      else checkOutput("fair.bubble", 32'(grant), 32'h0);
    end

    // Lock: agent 2 holds the port for 3 flits while agent 0 waits with a head.
    applyStimulus(4'b0101, 4'b0101, 4'b0001, 1'b0);
    checkOutput("lock.idle", 32'(grant), 32'h0);
    applyStimulus(4'b0101, 4'b0001, 4'b0001, 1'b0);
    checkOutput("lock.flit1", 32'(reqReady), 32'b0100);
    checkOutput("lock.sel", 32'(outSel), 32'd2);
    applyStimulus(4'b0101, 4'b0101, 4'b0001, 1'b0);
    checkOutput("lock.flit2_head_ignored", 32'(grant), 32'b0100);
    applyStimulus(4'b0101, 4'b0001, 4'b0101, 1'b0);
    checkOutput("lock.tail", 32'(reqReady), 32'b0100);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0);
    checkOutput("lock.bubble", 32'(grant), 32'h0);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0);
    checkOutput("lock.agent0", 32'(grant), 32'b0001);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Credit stall on a 6-flit packet from agent 1.
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0);
    checkOutput("stall.start_credits", 32'(credits), 32'd4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
      checkOutput("stall.flow", 32'(reqReady), 32'b0010);
    end
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
    checkOutput("stall.ready", 32'(reqReady), 32'h0);
    checkOutput("stall.grant_held", 32'(grant), 32'b0010);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1);
    checkOutput("stall.ret_same_cycle", 32'(reqReady), 32'h0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
    checkOutput("stall.resume", 32'(reqReady), 32'b0010);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1);
    checkOutput("stall.tail", 32'(reqReady), 32'b0010);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("stall.both_credits", 32'(credits), 32'd1);

    // Overflow pulse, owner stall, then reset mid-packet.
    for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("ovf.before", 32'(creditErr), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("ovf.pulse", 32'(creditErr), 32'h1);
    checkOutput("ovf.credits", 32'(credits), 32'd4);
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
    checkOutput("ovf.pulse_end", 32'(creditErr), 32'h0);
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("drop.sel", 32'(outSel), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("drop.grant_held", 32'(grant), 32'b1000);
    checkOutput("drop.no_xfer", 32'(outValid), 32'h0);
    @(posedge clk);
    #1;
    reqValid = 4'b1000;
    rst      = 1'b1;
    #1;
    checkOutput("async.grant", 32'(grant), 32'h0);
    checkOutput("async.credits", 32'(credits), 32'd4);
    checkOutput("async.out_sel", 32'(outSel), 32'h0);
    checkOutput("async.ready", 32'(reqReady), 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    reqValid = 4'b1111;
    reqHead  = 4'b1111;
    reqTail  = 4'b1111;
    @(negedge clk);
    checkOutput("post_reset.idle", 32'(grant), 32'h0);
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b0);
    checkOutput("post_reset.ptr0", 32'(grant), 32'b0001);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wormhole_out_arb.md
WORMHOLE_OUT_ARB -- requirements
Module: wormhole_out_arb

Interface
REQ-001 Parameter NUM_AGENTS, default 4: number of input requesters sharing one NoC output port.
REQ-002 Parameter CREDITS, default 4: downstream buffer depth in flits; CW = $clog2(CREDITS+1), IW = $clog2(NUM_AGENTS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_AGENTS  requester i presents a flit.
REQ-006 req_head  input  NUM_AGENTS  presented flit is a packet head; qualified by req_valid.
REQ-007 req_tail  input  NUM_AGENTS  presented flit is a packet tail; head and tail both set means a single-flit packet.
REQ-008 req_ready  output  NUM_AGENTS  flit of requester i is transferred this cycle; at most one bit set.
REQ-009 grant  output  NUM_AGENTS  registered one-hot owner of the port; held for the whole packet.
REQ-010 out_valid  output  1  a flit is forwarded this cycle; equals OR of req_ready.
REQ-011 out_sel  output  IW  index of the current owner; 0 when grant is 0.
REQ-012 credit_return  input  1  downstream freed one slot this cycle.
REQ-013 credits  output  CW  registered count of available downstream slots.
REQ-014 credit_err  output  1  registered one-cycle pulse on credit overflow.

Function
REQ-015 FSM states SHALL be IDLE and LOCKED.
REQ-016 In IDLE, candidates SHALL be the requesters with req_valid and req_head both set; non-head flits SHALL be ignored.
REQ-017 Winner SHALL be the first candidate at or after index ptr, searching upward with wrap from NUM_AGENTS-1 to 0.
REQ-018 With at least one candidate, the next edge SHALL set grant to the winner's one-hot and move the FSM to LOCKED; with none, the FSM SHALL stay in IDLE with grant 0.
REQ-019 In IDLE, req_ready and out_valid SHALL be 0.
REQ-020 In LOCKED, req_ready[owner] SHALL be req_valid[owner] AND (credits > 0), combinational from registered state; all other req_ready bits SHALL be 0.
REQ-021 Latency: a head presented at cycle t in IDLE SHALL be granted and transferable at cycle t+1.
REQ-022 A transfer with req_tail set SHALL, at the edge, return the FSM to IDLE, clear grant, and set ptr to owner+1 modulo NUM_AGENTS.
REQ-023 After a tail transfer at cycle t, the earliest next grant SHALL occur at t+2; the one-cycle bubble is intentional.
REQ-024 If the owner deasserts req_valid mid-packet, the FSM SHALL remain LOCKED with no transfer and no re-arbitration.
REQ-025 Credits SHALL decrement on a transfer, increment on credit_return, and remain unchanged when both occur in the same cycle.
REQ-026 With credits == 0, no transfer SHALL occur; a credit_return in that cycle SHALL make a transfer possible only in the next cycle.
REQ-027 A credit_return with credits == CREDITS and no transfer SHALL leave credits unchanged and pulse credit_err for one cycle.
REQ-028 The owner's head bit on later flits SHALL be ignored; only req_tail ends the lock.

Reset
REQ-029 Asserting rst SHALL immediately force the FSM to IDLE, grant 0, ptr 0, credits CREDITS, credit_err 0; req_ready, out_valid and out_sel are then 0.
REQ-030 Reset mid-packet SHALL abandon the packet; no state SHALL survive reset.

Structure
REQ-031 Shared package noc_pkg SHALL hold the arb_state_e enum (IDLE, LOCKED) and the default NUM_AGENTS and CREDITS constants.
REQ-032 A sub-module rr_pick (combinational: candidates and ptr in, one-hot winner and index out) SHALL implement REQ-017.
REQ-033 Estimated size: 150-250 lines of RTL.

Verification
REQ-034 Single-flit packet: req_valid=0001, head=tail=0001 -> grant=0001 next cycle, req_ready=0001 for one cycle, then IDLE; ptr=1; credits 4->3.
REQ-035 Fairness: all four requesters send continuous single-flit heads -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-036 Lock: agent 2 sends a 3-flit packet while agent 0 keeps a head pending -> grant=0100 for all 3 flits; agent 0 is granted 2 cycles after agent 2's tail.
REQ-037 Credit stall: CREDITS=4, no credit_return, 6-flit packet -> 4 transfers, then stall with grant held; one credit_return -> one more transfer a cycle later; simultaneous transfer and credit_return -> credits unchanged.
REQ-038 Overflow and reset: credit_return at credits=4 -> credit_err pulses once, credits stays 4; rst asserted mid-packet -> grant=0, FSM IDLE, credits=4, ptr=0 without waiting for a clock edge.
